program_counter: RTL
====================

# program_counter

Program-counter stage of the 8-bit core. It sits directly upstream of the halt detector: it generates `PC_Curr` and the latched `PC_End` that the detector compares, and it consumes the detector's `halt`. It handles start, stall, absolute and relative branches, halting, and a retired-instruction counter for performance readout.

## Interface
Parameters:
- `PC_W`, 8: PC and program-end width.
- `CNT_W`, 16: width of the retired-instruction counter.
- `RESET_PC`, 0: value of `PC_Curr` while in reset and in IDLE.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces reset state immediately.
- `start`  in  1  level-sampled; starts a run when in IDLE or HALTED.
- `start_addr`  in  PC_W  first PC of the run, sampled with `start`.
- `end_addr`  in  PC_W  program end, latched into `PC_End` on `start`.
- `stall`  in  1  holds PC and counter for this cycle.
- `br_abs_en`  in  1  absolute branch request.
- `br_abs_tgt`  in  PC_W  absolute target.
- `br_rel_en`  in  1  relative branch request.
- `br_rel_off`  in  PC_W  two's-complement offset.
- `halt`  in  1  from halt detector.
- `PC_Curr`  out  PC_W  registered current PC.
- `PC_End`  out  PC_W  registered program end for the detector.
- `running`  out  1  1 while in RUN.
- `done`  out  1  one-cycle pulse on the RUN→HALTED transition.
- `instr_count`  out  CNT_W  instructions retired in the current run.

## Operation
- States: IDLE, RUN, HALTED.
- Reset values: state IDLE, `PC_Curr`=`RESET_PC`, `PC_End`=0, `running`=0, `done`=0, `instr_count`=0.
- IDLE/HALTED with `start`=1: next state RUN. `PC_Curr`←`start_addr`, `PC_End`←`end_addr`, `instr_count`←0.
- IDLE/HALTED with `start`=0: all registers hold. In HALTED, `PC_Curr` keeps the halted PC.
- RUN: `start` is ignored. The next PC is chosen by the first matching rule:
  1. `halt`: go to HALTED, PC frozen, `done`=1 for one cycle, counter frozen.
  2. `stall`: PC and counter hold.
  3. `br_abs_en`: PC←`br_abs_tgt`.
  4. `br_rel_en`: PC←(PC + `br_rel_off`) mod 2^PC_W, signed offset.
  5. Otherwise: PC←(PC+1) mod 2^PC_W. 0xFF wraps to 0x00.
- Any PC update under rules 3–5 increments `instr_count` by 1. The counter saturates at all-ones and never wraps.
- A relative offset of 0 is legal and produces a self-loop that still counts.
- `running` is 1 exactly when state is RUN. `done` is 0 at all other times.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `start` sampled at edge N: `running`=1 and `PC_Curr`=`start_addr` visible after edge N. The first increment happens at edge N+1.
- `halt` sampled high at edge N while in RUN: after edge N, `running`=0, `done`=1, and `PC_Curr` is unchanged from before edge N. `done` drops after edge N+1.
- `halt` must be acted on in the same cycle it is seen, so `PC_Curr` never advances past the halting PC.
- Both branch enables high together: the absolute branch wins.
- `halt` and a branch in the same cycle: `halt` wins and the branch is dropped.
- `reset` low mid-run: all outputs take their reset values asynchronously. Deassertion is synchronised externally, and the first active edge afterwards sees IDLE.

## Structure
- Package `fetch_pkg` holds:
  - the state enum `pc_state_t` (IDLE, RUN, HALTED);
  - the `PC_W` default;
  - the `pc_t` typedef.
- Sub-module `next_pc_calc` (combinational) contains the priority mux and the modular add. The top level holds the FSM, the registers and the counter.

## Test plan
- Reset, then `start` with `start_addr`=0 and `end_addr`=250, no other stimulus → `PC_Curr` reads 0,1,2,… on consecutive cycles and `instr_count` tracks it.
- Run from `start_addr`=0xFE → `PC_Curr` goes 0xFE, 0xFF, 0x00. When `halt` is forced high at `PC_Curr`=0x05 → `PC_Curr` stays 0x05, `done` pulses once and `running`=0.
- At `PC_Curr`=0x10, `br_rel_off`=0xFC (−4) → next PC 0x0C. In the same cycle with `br_abs_en`=1 and `br_abs_tgt`=0x40 → next PC 0x40.
- `stall` held for 3 cycles at PC 0x20 → PC stays 0x20 and `instr_count` is unchanged. `halt` together with a branch → PC frozen and HALTED.
- From HALTED, `start` with `start_addr`=0 and `end_addr`=120 → `PC_End`=120, counter cleared, run resumes. `reset` pulled low mid-run → outputs immediately at reset values.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch-side pipeline: the program-counter FSM states
// and the default PC width.
package fetch_pkg;

    localparam int DEFAULT_PC_W = 8;

    typedef logic [DEFAULT_PC_W-1:0] pc_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

endpackage : fetch_pkg

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the RUN state: halt, stall, absolute
// branch, relative branch, sequential increment, in that priority order.
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int PC_W = DEFAULT_PC_W
) (
    input  logic [PC_W-1:0] pc,
    input  logic            halt,
    input  logic            stall,
    input  logic            br_abs_en,
    input  logic [PC_W-1:0] br_abs_tgt,
    input  logic            br_rel_en,
    input  logic [PC_W-1:0] br_rel_off,
    output logic [PC_W-1:0] next_pc,
    output logic            advance
);

    // Adding the raw offset at PC width is exactly a signed add modulo 2^PC_W.
    logic [PC_W-1:0] rel_sum;
    logic [PC_W-1:0] inc_sum;

    assign rel_sum = pc + br_rel_off;
    assign inc_sum = pc + PC_W'(1);

    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        next_pc = pc;
        advance = 1'b0;
        if (!halt && !stall) begin
            advance = 1'b1;
            if (br_abs_en) begin
                next_pc = br_abs_tgt;
            end else if (br_rel_en) begin
                next_pc = rel_sum;
            end else begin
                next_pc = inc_sum;
            end
        end
    end

endmodule : next_pc_calc

// File: rtl/program_counter.sv
// Program-counter stage: run-control FSM, PC and program-end registers, and a
// saturating retired-instruction counter feeding the halt detector.
module program_counter
    import fetch_pkg::*;
#(
    parameter int              PC_W     = DEFAULT_PC_W,
    parameter int              CNT_W    = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  start_addr,
    input  logic [PC_W-1:0]  end_addr,
    input  logic             stall,
    input  logic             br_abs_en,
    input  logic [PC_W-1:0]  br_abs_tgt,
    input  logic             br_rel_en,
    input  logic [PC_W-1:0]  br_rel_off,
    input  logic             halt,
    output logic [PC_W-1:0]  PC_Curr,
    output logic [PC_W-1:0]  PC_End,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] instr_count
);

    pc_state_t       state;
    logic [PC_W-1:0] next_pc;
    logic            advance;

    next_pc_calc #(
        .PC_W (PC_W)
    ) u_next_pc_calc (
        .pc         (PC_Curr),
        .halt       (halt),
        .stall      (stall),
        .br_abs_en  (br_abs_en),
        .br_abs_tgt (br_abs_tgt),
        .br_rel_en  (br_rel_en),
        .br_rel_off (br_rel_off),
        .next_pc    (next_pc),
        .advance    (advance)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            PC_Curr     <= RESET_PC;
            PC_End      <= '0;
            running     <= 1'b0;
            done        <= 1'b0;
            instr_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        state       <= RUN;
                        running     <= 1'b1;
                        PC_Curr     <= start_addr;
                        PC_End      <= end_addr;
                        instr_count <= '0;
                    end
                end
                RUN: begin
                    // Halt is acted on in the cycle it is seen, so the PC
                    // never moves past the halting instruction.
                    if (halt) begin
                        state   <= HALTED;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (advance) begin
                        PC_Curr <= next_pc;
                        if (!(&instr_count)) begin
                            instr_count <= instr_count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule : program_counter
